// File: rtl/cpu_core_mc_if.sv
// Memory-side handshake bundle for cpu_core_mc: instruction fetch and data access channels.
// The core drives requests through the master modport; ROM/RAM models answer through slave.
interface cpu_core_mc_if #(
   parameter int DATA_W  = 8,
   parameter int PC_W    = 8,
   parameter int INSTR_W = 24
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_ack;

   logic               dmem_req;
   logic               dmem_we;
   logic [DATA_W-1:0]  dmem_addr;
   logic [DATA_W-1:0]  dmem_wdata;
   logic [DATA_W-1:0]  dmem_rdata;
   logic               dmem_ack;

   modport master (
      output imem_req, imem_addr,
      input  imem_rdata, imem_ack,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rdata, imem_ack,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/cpu_core_mc.sv
// Multi-cycle parametrised core with req/ack instruction and data memory ports.
// Define CPU_SINGLE_STEP_EN to let a step pulse in IDLE execute exactly one instruction.
module cpu_core_mc #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 4,
   parameter int PC_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              step,
   cpu_core_mc_if.master     bus,
   output logic [PC_W-1:0]   pc,
   output logic              halted,
   output logic              zero_flag,
   output logic              carry_flag,
   output logic              retire,
   input  logic [REG_AW-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);
   localparam int NUM_REGS = 2**REG_AW;
   localparam int INSTR_W  = 4 + 3*REG_AW + DATA_W;

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALTED} state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d, pcNext;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               zero_q, zero_d, carry_q, carry_d;
   logic               retire_q, retire_d;
   logic [DATA_W-1:0]  addr_q, addr_d, wdata_q, wdata_d;
   logic               we_q, we_d;
   logic [DATA_W-1:0]  regs_q [NUM_REGS];

   logic [3:0]         op;
   logic [REG_AW-1:0]  rd, ra, rb;
   logic [DATA_W-1:0]  imm, raVal, rbVal;
   logic [DATA_W:0]    aluWide;
   logic               wrEn;
   logic [REG_AW-1:0]  wrAddr;
   logic [DATA_W-1:0]  wrData;
   logic               startReq;

`ifdef CPU_SINGLE_STEP_EN
   assign startReq = run | step;
`else
   logic unusedStep;
   assign unusedStep = step;
   assign startReq   = run;
`endif

   assign {op, rd, ra, rb, imm} = ir_q;
   assign raVal  = regs_q[ra];
   assign rbVal  = regs_q[rb];
   assign pcNext = pc_q + PC_W'(1);

   // ALU result with the carry/borrow bit carried in the top position
   always_comb begin
      aluWide = '0;
      case (op)
         4'h0:    aluWide = {1'b0, raVal} + {1'b0, rbVal};
         4'h1:    aluWide = {1'b0, raVal} - {1'b0, rbVal};
         4'h2:    aluWide = {1'b0, raVal & rbVal};
         4'h3:    aluWide = {1'b0, raVal | rbVal};
         4'h4:    aluWide = {1'b0, raVal ^ rbVal};
         4'h5:    aluWide = {raVal, 1'b0};
         4'h6:    aluWide = {raVal[0], 1'b0, raVal[DATA_W-1:1]};
         4'h7:    aluWide = {1'b0, ~raVal};
         4'h8:    aluWide = {1'b0, imm};
         default: aluWide = '0;
      endcase
   end

   // Sequencer: fetch, execute, optional memory phase, then stop or continue by run
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      retire_d = 1'b0;
      wrEn     = 1'b0;
      wrAddr   = rd;
      wrData   = aluWide[DATA_W-1:0];
      case (state_q)
         IDLE: begin
            if (startReq) state_d = FETCH;
         end
         FETCH: begin
            if (bus.imem_ack) begin
               ir_d    = bus.imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d  = run ? FETCH : IDLE;
            retire_d = 1'b1;
            pc_d     = pcNext;
            case (op)
               4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                  wrEn    = 1'b1;
                  zero_d  = (aluWide[DATA_W-1:0] == '0);
                  carry_d = aluWide[DATA_W];
               end
               4'h7, 4'h8: wrEn = 1'b1;
               4'h9, 4'hA: begin
                  state_d  = MEM;
                  retire_d = 1'b0;
                  pc_d     = pc_q;
                  addr_d   = raVal + imm;
                  wdata_d  = rbVal;
                  we_d     = (op == 4'hA);
               end
               4'hB: pc_d = PC_W'(imm);
               4'hC: if (zero_q) pc_d = PC_W'(imm);
               4'hD: pc_d = PC_W'(raVal);
               4'hF: begin
                  state_d = HALTED;
                  pc_d    = pc_q;
               end
               default: ;
            endcase
         end
         MEM: begin
            if (bus.dmem_ack) begin
               if (!we_q) begin
                  wrEn   = 1'b1;
                  wrData = bus.dmem_rdata;
               end
               pc_d     = pcNext;
               retire_d = 1'b1;
               state_d  = run ? FETCH : IDLE;
            end
         end
         HALTED: ;
         default: state_d = IDLE;
      endcase
   end

   // Architectural and control state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         retire_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         retire_q <= retire_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
      end
   end

   // Register file; operands are read combinationally so EXEC sees pre-write values
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wrEn) begin
         regs_q[wrAddr] <= wrData;
      end
   end

   assign bus.imem_req   = (state_q == FETCH);
   assign bus.imem_addr  = pc_q;
   assign bus.dmem_req   = (state_q == MEM);
   assign bus.dmem_we    = (state_q == MEM) & we_q;
   assign bus.dmem_addr  = addr_q;
   assign bus.dmem_wdata = wdata_q;

   assign pc         = pc_q;
   assign halted     = (state_q == HALTED);
   assign zero_flag  = zero_q;
   assign carry_flag = carry_q;
   assign retire     = retire_q;
   assign dbg_data   = regs_q[dbg_sel];
endmodule

// File: tb/tb_cpu_core_mc.sv
// Self-checking bench for cpu_core_mc: wait-state memory models, directed programs and
// random programs compared against an instruction-level reference interpreter.
`timescale 1ns/1ps
module tb_cpu_core_mc;
   localparam int DW  = 8;
   localparam int RAW = 4;
   localparam int PW  = 8;
   localparam int IW  = 4 + 3*RAW + DW;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           run = 1'b0;
   logic           step = 1'b0;
   logic [PW-1:0]  pc;
   logic           halted, zero_flag, carry_flag, retire;
   logic [RAW-1:0] dbgSel = '0;
   logic [DW-1:0]  dbgData;

   cpu_core_mc_if #(.DATA_W(DW), .PC_W(PW), .INSTR_W(IW)) bus();

   cpu_core_mc #(.DATA_W(DW), .REG_AW(RAW), .PC_W(PW)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .bus(bus),
      .pc(pc), .halted(halted), .zero_flag(zero_flag), .carry_flag(carry_flag),
      .retire(retire), .dbg_sel(dbgSel), .dbg_data(dbgData)
   );

   always #5 clk = ~clk;

   // Memories, wait-state settings and bookkeeping shared with the responders
   bit [IW-1:0] imem [256];
   bit [DW-1:0] dmem [256];
   int  iWaitMax = 0, dWaitMax = 0;
   bit  waitRandom = 1'b0;
   int  iCnt, iDelay, dCnt, dDelay, dRun;
   bit  iBusy, dBusy;
   logic [DW-1:0] dAddr0, dWdata0;
   logic dWe0;
   int  fetchTotal = 0, dTotal = 0, dUnstable = 0, retireTotal = 0, cycleCount = 0;
   bit [PW-1:0] fetchLog [65536];
   int  dRunLog [1024];
   int  retireCycle [65536];

   // Instruction ROM with programmable wait states
   always @(negedge clk) begin
      if (bus.imem_req === 1'b1) begin
         if (!iBusy) begin
            iBusy = 1'b1;
            iCnt = 0;
            iDelay = waitRandom ? $urandom_range(0, iWaitMax) : iWaitMax;
         end
         if (iCnt >= iDelay) begin
            bus.imem_ack = 1'b1;
            bus.imem_rdata = imem[bus.imem_addr];
            fetchLog[fetchTotal % 65536] = bus.imem_addr;
            fetchTotal++;
            iBusy = 1'b0;
         end else begin
            bus.imem_ack = 1'b0;
            iCnt++;
         end
      end else begin
         bus.imem_ack = 1'b0;
         bus.imem_rdata = '0;
         iBusy = 1'b0;
      end
   end

   // Data RAM with wait states; also measures request length and stability
   always @(negedge clk) begin
      if (bus.dmem_req === 1'b1) begin
         if (!dBusy) begin
            dBusy = 1'b1;
            dCnt = 0;
            dRun = 0;
            dAddr0 = bus.dmem_addr;
            dWdata0 = bus.dmem_wdata;
            dWe0 = bus.dmem_we;
            dDelay = waitRandom ? $urandom_range(0, dWaitMax) : dWaitMax;
         end
         dRun++;
         if (bus.dmem_addr !== dAddr0 || bus.dmem_we !== dWe0 || bus.dmem_wdata !== dWdata0)
            dUnstable++;
         if (dCnt >= dDelay) begin
            bus.dmem_ack = 1'b1;
            if (bus.dmem_we === 1'b1) dmem[bus.dmem_addr] = bus.dmem_wdata;
            else bus.dmem_rdata = dmem[bus.dmem_addr];
            dRunLog[dTotal % 1024] = dRun;
            dTotal++;
            dBusy = 1'b0;
         end else begin
            bus.dmem_ack = 1'b0;
            dCnt++;
         end
      end else begin
         bus.dmem_ack = 1'b0;
         bus.dmem_rdata = '0;
         dBusy = 1'b0;
      end
   end

   always @(negedge clk) begin
      cycleCount++;
      if (retire === 1'b1) begin
         retireCycle[retireTotal % 65536] = cycleCount;
         retireTotal++;
      end
   end

   int checkCount = 0, passCount = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   function automatic bit [IW-1:0] enc(input int op, input int rd, input int ra, input int rb, input int imm);
      bit [3:0] o, d, x, y;
      bit [7:0] m;
      o = op[3:0]; d = rd[3:0]; x = ra[3:0]; y = rb[3:0]; m = imm[7:0];
      return {o, d, x, y, m};
   endfunction

   // Reference interpreter: one instruction per loop iteration, architectural state only
   int mReg [16];
   int mMem [256];
   int mPc, mZ, mC, mRetired;

   task automatic modelRun();
      int iw, op, rd, ra, rb, imm, a, b, s;
      bit done;
      for (int i = 0; i < 16; i++) mReg[i] = 0;
      mPc = 0; mZ = 0; mC = 0; mRetired = 0; done = 1'b0;
      while (!done && mRetired < 4000) begin
         iw = int'(imem[mPc]);
         op = (iw >> 20) & 15; rd = (iw >> 16) & 15; ra = (iw >> 12) & 15;
         rb = (iw >> 8) & 15;  imm = iw & 255;
         a = mReg[ra]; b = mReg[rb]; s = -1;
         mRetired++;
         case (op)
            0: begin s = (a + b) % 256; mC = (a + b > 255) ? 1 : 0; end
            1: begin s = (a - b + 256) % 256; mC = (a < b) ? 1 : 0; end
            2: begin s = a & b; mC = 0; end
            3: begin s = a | b; mC = 0; end
            4: begin s = a ^ b; mC = 0; end
            5: begin s = (a * 2) % 256; mC = (a >= 128) ? 1 : 0; end
            6: begin s = a / 2; mC = a % 2; end
            7: s = 255 - a;
            8: s = imm;
            9: s = mMem[(a + imm) % 256];
            10: mMem[(a + imm) % 256] = b;
            default: ;
         endcase
         if (op <= 6) mZ = (s == 0) ? 1 : 0;
         if (s >= 0) mReg[rd] = s;
         case (op)
            11: mPc = imm;
            12: mPc = (mZ == 1) ? imm : (mPc + 1) % 256;
            13: mPc = a % 256;
            15: done = 1'b1;
            default: mPc = (mPc + 1) % 256;
         endcase
      end
   endtask

   task automatic fillHalt();
      for (int i = 0; i < 256; i++) imem[i] = enc(15, 0, 0, 0, 0);
   endtask

   task automatic doReset();
      @(negedge clk);
      run = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic readReg(input int idx, output logic [DW-1:0] v);
      dbgSel = idx[RAW-1:0];
      #1;
      v = dbgData;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Execute the loaded program from reset until HALT and compare with the interpreter
   task automatic applyStimulus(input string name, input int budget, output int r0);
      int n, bad;
      logic [DW-1:0] v;
      doReset();
      r0 = retireTotal;
      run = 1'b1;
      n = 0;
      while (halted !== 1'b1 && n < budget) begin
         @(negedge clk); #1; n++;
      end
      waitCycles(2);
      run = 1'b0;
      modelRun();
      checkOutput({name, ".halted"}, halted, 1);
      checkOutput({name, ".pc"}, pc, mPc);
      checkOutput({name, ".Z"}, zero_flag, mZ);
      checkOutput({name, ".C"}, carry_flag, mC);
      checkOutput({name, ".retired"}, retireTotal - r0, mRetired);
      for (int i = 0; i < 16; i++) begin
         readReg(i, v);
         checkOutput($sformatf("%s.r%0d", name, i), v, mReg[i]);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (int'(dmem[i]) != mMem[i]) bad++;
      checkOutput({name, ".dmemDiffs"}, bad, 0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int r0, f0, d0, u0, n;
      logic [DW-1:0] v;

      fillHalt();
      // Reset state
      waitCycles(3);
      checkOutput("rst.pc", pc, 0);
      checkOutput("rst.halted", halted, 0);
      checkOutput("rst.retire", retire, 0);
      checkOutput("rst.imemReq", bus.imem_req, 0);
      checkOutput("rst.dmemReq", bus.dmem_req, 0);
      checkOutput("rst.dmemWe", bus.dmem_we, 0);
      checkOutput("rst.Z", zero_flag, 0);
      checkOutput("rst.C", carry_flag, 0);
      readReg(5, v);
      checkOutput("rst.r5", v, 0);

      // Basic program, zero-wait memories
      fillHalt();
      imem[0] = enc(8, 1, 0, 0, 5);
      imem[1] = enc(8, 2, 0, 0, 3);
      imem[2] = enc(0, 3, 1, 2, 0);
      imem[3] = enc(15, 0, 0, 0, 0);
      applyStimulus("add", 100, r0);
      readReg(3, v);
      checkOutput("add.r3is8", v, 8);
      checkOutput("add.pcIs3", pc, 3);
      checkOutput("add.fourRetires", retireTotal - r0, 4);
      checkOutput("add.gapAlu", retireCycle[(r0 + 2) % 65536] - retireCycle[(r0 + 1) % 65536], 2);
      checkOutput("add.gapHalt", retireCycle[(r0 + 3) % 65536] - retireCycle[(r0 + 2) % 65536], 2);

      // Reset while HALTED
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rstHalt.halted", halted, 0);
      checkOutput("rstHalt.pc", pc, 0);
      readReg(3, v);
      checkOutput("rstHalt.r3", v, 0);
      @(negedge clk);
      rst = 1'b1;

      // SUB with borrow
      fillHalt();
      imem[0] = enc(8, 1, 0, 0, 2);
      imem[1] = enc(8, 2, 0, 0, 3);
      imem[2] = enc(1, 3, 1, 2, 0);
      imem[3] = enc(15, 0, 0, 0, 0);
      applyStimulus("subBorrow", 100, r0);
      readReg(3, v);
      checkOutput("subBorrow.rdFF", v, 8'hFF);
      checkOutput("subBorrow.C1", carry_flag, 1);
      checkOutput("subBorrow.Z0", zero_flag, 0);

      // SUB to zero, then taken JZ
      fillHalt();
      imem[0] = enc(8, 1, 0, 0, 7);
      imem[1] = enc(8, 2, 0, 0, 7);
      imem[2] = enc(1, 4, 1, 2, 0);
      imem[3] = enc(12, 0, 0, 0, 8'h20);
      applyStimulus("subZero", 100, r0);
      checkOutput("subZero.pc20", pc, 8'h20);
      checkOutput("subZero.Z1", zero_flag, 1);
      checkOutput("subZero.C0", carry_flag, 0);

      // Store then load with three wait states on data memory
      fillHalt();
      dWaitMax = 3;
      imem[0] = enc(8, 1, 0, 0, 8'h05);
      imem[1] = enc(8, 2, 0, 0, 8'hA7);
      imem[2] = enc(10, 0, 1, 2, 8'h10);
      imem[3] = enc(9, 4, 1, 0, 8'h10);
      imem[4] = enc(15, 0, 0, 0, 0);
      d0 = dTotal;
      u0 = dUnstable;
      applyStimulus("stld", 200, r0);
      readReg(4, v);
      checkOutput("stld.r4", v, 8'hA7);
      checkOutput("stld.stReqCycles", dRunLog[d0 % 1024], 4);
      checkOutput("stld.ldReqCycles", dRunLog[(d0 + 1) % 1024], 4);
      checkOutput("stld.stable", dUnstable - u0, 0);
      checkOutput("stld.ram15", dmem[8'h15], 8'hA7);
      dWaitMax = 0;

      // ADD overflow plus JR
      fillHalt();
      imem[0] = enc(8, 1, 0, 0, 8'hFF);
      imem[1] = enc(8, 2, 0, 0, 8'h01);
      imem[2] = enc(0, 3, 1, 2, 0);
      imem[3] = enc(8, 5, 0, 0, 8'h30);
      imem[4] = enc(13, 0, 5, 0, 0);
      applyStimulus("ovf", 100, r0);
      readReg(3, v);
      checkOutput("ovf.r3zero", v, 0);
      checkOutput("ovf.C1", carry_flag, 1);
      checkOutput("ovf.Z1", zero_flag, 1);
      checkOutput("ovf.jrPc", pc, 8'h30);

      // PC wrap from 0xFF to 0x00
      fillHalt();
      imem[0] = enc(11, 0, 0, 0, 8'hFF);
      imem[255] = enc(14, 0, 0, 0, 0);
      doReset();
      f0 = fetchTotal;
      run = 1'b1;
      n = 0;
      while (fetchTotal < f0 + 3 && n < 50) begin @(negedge clk); #1; n++; end
      checkOutput("wrap.fetchFF", fetchLog[(f0 + 1) % 65536], 8'hFF);
      checkOutput("wrap.fetch00", fetchLog[(f0 + 2) % 65536], 8'h00);

      // run dropped during EXEC of the first instruction
      fillHalt();
      imem[0] = enc(8, 1, 0, 0, 9);
      imem[1] = enc(8, 2, 0, 0, 4);
      doReset();
      f0 = fetchTotal;
      r0 = retireTotal;
      run = 1'b1;
      n = 0;
      while (fetchTotal == f0 && n < 20) begin @(negedge clk); #1; n++; end
      @(negedge clk);
      run = 1'b0;
      waitCycles(5);
      checkOutput("runDrop.fetches", fetchTotal - f0, 1);
      checkOutput("runDrop.retires", retireTotal - r0, 1);
      checkOutput("runDrop.pc", pc, 1);
      checkOutput("runDrop.imemReq", bus.imem_req, 0);
      readReg(1, v);
      checkOutput("runDrop.r1", v, 9);

      // Reset during an outstanding fetch, then restart from address 0
      fillHalt();
      imem[0] = enc(11, 0, 0, 0, 8'h40);
      imem[8'h40] = enc(14, 0, 0, 0, 0);
      iWaitMax = 20;
      doReset();
      run = 1'b1;
      n = 0;
      while (!(pc === 8'h40 && bus.imem_req === 1'b1) && n < 100) begin @(negedge clk); #1; n++; end
      checkOutput("rstFetch.reached", pc, 8'h40);
      rst = 1'b0;
      #1;
      checkOutput("rstFetch.imemReq", bus.imem_req, 0);
      checkOutput("rstFetch.pc", pc, 0);
      iWaitMax = 0;
      f0 = fetchTotal;
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (fetchTotal == f0 && n < 20) begin @(negedge clk); #1; n++; end
      checkOutput("rstFetch.restart", fetchLog[f0 % 65536], 0);
      run = 1'b0;

      // Random programs with random wait states on both memories
      waitRandom = 1'b1;
      iWaitMax = 3;
      dWaitMax = 3;
      for (int p = 0; p < 6; p++) begin
         int op, imm;
         fillHalt();
         for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 14);
            if (op == 13 || $urandom_range(0, 3) == 0) op = 8;
            imm = $urandom_range(0, 255);
            if (op == 11 || op == 12) imm = $urandom_range(i + 1, 255);
            imem[i] = enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), imm);
         end
         applyStimulus($sformatf("rand%0d", p), 3000, r0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle 8-bit core.
- Scalable data width, register count and PC width.
- Instruction and data memories are external, reached over req/ack handshake ports, so wait-state ROM/RAM can be attached.
- Adds run/step control, flags, halted status and a debug register read port.
- Sits between the board top level (display/LED wiring) and the instruction ROM / data RAM.

Parameters:
- DATA_W, 8: datapath, register and data-memory address width.
- REG_AW, 4: register address width; NUM_REGS = 2**REG_AW.
- PC_W, 8: program counter / instruction address width.
- INSTR_W, 4+3*REG_AW+DATA_W: instruction width (24 at defaults); derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = fetch new instructions.
- step  in  1  single-cycle pulse; see Optional Feature.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_rdata  in  INSTR_W  instruction word, valid when imem_ack=1.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DATA_W  ra + imm, modulo 2**DATA_W.
- dmem_wdata  out  DATA_W  rb value for stores.
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1.
- dmem_ack  in  1  data access complete.
- pc  out  PC_W  current program counter.
- halted  out  1  core executed HALT.
- zero_flag  out  1  last ALU result was zero.
- carry_flag  out  1  last ALU carry/borrow.
- retire  out  1  one-cycle pulse per completed instruction.
- dbg_sel  in  REG_AW  debug register select.
- dbg_data  out  DATA_W  combinational read of reg[dbg_sel].

Behaviour:
- Instruction format, MSB down: op[3:0], rd, ra, rb (REG_AW bits each), imm (DATA_W bits).
- Opcodes (flags are updated only by 0–6):
  - 0 ADD: rd=ra+rb; C = carry-out.
  - 1 SUB: rd=ra-rb; C = borrow (ra<rb unsigned).
  - 2 AND, 3 OR, 4 XOR: C=0.
  - 5 SHL: rd=ra<<1; C = ra msb.
  - 6 SHR: rd=ra>>1 (logical); C = ra lsb.
  - 7 NOT: rd=~ra; flags unchanged.
  - 8 LDI: rd=imm.
  - 9 LD: rd=mem[ra+imm].
  - A ST: mem[ra+imm]=rb.
  - B JMP: pc=imm[PC_W-1:0], zero-extended.
  - C JZ: if zero_flag, pc=imm; else pc+1.
  - D JR: pc=ra, truncated/zero-extended to PC_W.
  - E NOP.
  - F HALT.
- Z = (result==0). Non-jump instructions advance pc by 1, wrapping modulo 2**PC_W.
- FSM states: IDLE, FETCH, EXEC, MEM, HALTED.
  - IDLE: if run=1 (or a step is pending), go to FETCH next cycle. Otherwise stay; no requests.
  - FETCH: hold imem_req=1 with imem_addr=pc until imem_ack. On the ack edge, latch the instruction into the IR and go to EXEC.
  - EXEC, one cycle:
    - ALU/LDI/NOT: write rd and flags, update pc.
    - Jumps: update pc.
    - LD/ST: go to MEM.
    - HALT: go to HALTED.
    - Otherwise return to FETCH if run=1, else IDLE.
  - MEM: hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until dmem_ack. On the ack edge, LD writes rd from dmem_rdata and pc increments. Next state is FETCH or IDLE, by the run rule.
  - HALTED: terminal; halted=1; no requests. Leave only via rst.
- retire pulses in the cycle after the final state of each instruction. HALT itself retires.
- Zero-wait latency (ack same cycle as req): ALU, jump and LDI instructions take 2 cycles; LD/ST take 3.
- run deasserted mid-instruction: the current instruction completes; the core stops at the next fetch boundary, in IDLE.
- An ack without a matching req is ignored.
- Requests never drop before ack, except on reset.
- Write to rd and read of the same register within EXEC: the read returns the old value.
- All registers are general purpose; no hardwired zero.
- Reset (asynchronous, mid-transaction allowed):
  - state=IDLE, pc=0, all registers 0, flags 0.
  - halted=0, retire=0, imem_req=0, dmem_req=0, dmem_we=0.
  - An in-flight ack arriving after reset release is ignored.

Optional Feature:
- Macro: CPU_SINGLE_STEP_EN.
- Defined: with run=0, a step pulse while in IDLE executes exactly one full instruction (including any MEM wait), then returns to IDLE. A step pulse outside IDLE is ignored.
- Undefined: step is unconnected internally; only run controls execution.

Test Plan:
- Program "LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT", zero-wait acks, run=1 -> r3=8 via dbg; pc=3; halted=1; 4 retire pulses; Z=0, C=0.
- SUB with r1=2, r2=3 -> rd=0xFF, C=1, Z=0. SUB with r1=r2=7 -> rd=0, Z=1, C=0. JZ then taken to imm=0x20 -> pc=0x20.
- ST r2 to [r1+0x10] then LD r4 from [r1+0x10], with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with stable addr; r4 equals the stored value.
- Sequential execution at pc=0xFF with an 8-bit PC -> next fetch address 0x00. ADD 0xFF+0x01 -> result 0, C=1, Z=1.
- run dropped in the EXEC cycle -> instruction retires; no further imem_req; core in IDLE; pc = next address.
- rst asserted while imem_req=1 and during HALTED -> imem_req=0 and halted=0 immediately; pc=0. After release with run=1, fetch restarts at address 0.
